// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte SYNC/OP/ADDR/DATA/CHK frames from a UART
// byte stream, validates an XOR checksum and presents good commands on a
// valid/ready interface, with one-clock pulses for checksum, timeout and
// overrun errors.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [7:0]  cmd_wdata,
  output logic        chk_err,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [15:0] frame_cnt
);

  // 16 bits covers the default; larger timeouts get a wider counter
  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 65535) ? $clog2(TIMEOUT_CLKS) : 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_OP,
    S_ADDR,
    S_DATA,
    S_CHK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       op_q;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;

  logic chk_ok;
  logic load_ok;

  // Checksum of the shadowed frame against the incoming CHK byte
  assign chk_ok  = (rx_data == (op_q ^ addr_q ^ data_q));
  // Output slot is free now or is being emptied on this same edge
  assign load_ok = !cmd_valid || cmd_ready;

  // Frame FSM, inter-byte timeout, output holding register and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_SYNC;
      tmo_cnt     <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;

      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      if (rx_ready) begin
        // A byte arriving on the expiry clock still wins over the timeout
        tmo_cnt <= '0;
        case (state)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state <= S_OP;
            end
          end
          S_OP: begin
            op_q  <= rx_data;
            state <= S_ADDR;
          end
          S_ADDR: begin
            addr_q <= rx_data;
            state  <= S_DATA;
          end
          S_DATA: begin
            data_q <= rx_data;
            state  <= S_CHK;
          end
          S_CHK: begin
            state <= S_SYNC;
            if (!chk_ok) begin
              chk_err <= 1'b1;
            end else if (load_ok) begin
              cmd_valid <= 1'b1;
              cmd_op    <= op_q;
              cmd_addr  <= addr_q;
              cmd_wdata <= data_q;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              overrun_err <= 1'b1;
            end
          end
          default: begin
            state <= S_SYNC;
          end
        endcase
      end else if (state != S_SYNC) begin
        if (tmo_cnt == CNT_LAST) begin
          state       <= S_SYNC;
          timeout_err <= 1'b1;
          tmo_cnt     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenario tasks plus a command scoreboard
// that is filled as frames are sent and drained as the DUT hands commands off.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        chk_err;
  logic        timeout_err;
  logic        overrun_err;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_chk = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  int exp_frames = 0;

  logic [23:0] exp_q[$];

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .chk_err    (chk_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard and pulse monitor, sampled mid-cycle
  logic        hold_prev = 1'b0;
  logic [23:0] hold_val  = '0;
  logic        chk_prev = 1'b0, tmo_prev = 1'b0, ovr_prev = 1'b0;
  always @(negedge clk) begin
    logic [23:0] exp;
    if (rst) begin
      hold_prev = 1'b0;
      chk_prev = 1'b0; tmo_prev = 1'b0; ovr_prev = 1'b0;
    end else begin
      if (hold_prev && cmd_valid) begin
        n_cmp++;
        if ({cmd_op, cmd_addr, cmd_wdata} !== hold_val) begin
          n_err++;
          $display("FAIL hold_stable: got %h required %h", {cmd_op, cmd_addr, cmd_wdata}, hold_val);
        end
      end
      if (cmd_valid && cmd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %h required none", {cmd_op, cmd_addr, cmd_wdata});
        end else begin
          exp = exp_q.pop_front();
          if ({cmd_op, cmd_addr, cmd_wdata} !== exp) begin
            n_err++;
            $display("FAIL sb_cmd: got %h required %h", {cmd_op, cmd_addr, cmd_wdata}, exp);
          end
        end
      end
      if ((chk_err && chk_prev) || (timeout_err && tmo_prev) || (overrun_err && ovr_prev)) begin
        n_cmp++;
        n_err++;
        $display("FAIL pulse_width: chk=%b tmo=%b ovr=%b high two clks, required one", chk_err, timeout_err, overrun_err);
      end
      if (chk_err) n_chk++;
      if (timeout_err) n_tmo++;
      if (overrun_err) n_ovr++;
      chk_prev = chk_err; tmo_prev = timeout_err; ovr_prev = overrun_err;
      hold_prev = cmd_valid && !cmd_ready;
      hold_val  = {cmd_op, cmd_addr, cmd_wdata};
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input logic good);
    logic [7:0] chk;
    chk = op ^ addr ^ data;
    if (!good) chk = ~chk;
    send_byte(8'hA5);
    send_byte(op);
    send_byte(addr);
    send_byte(data);
    send_byte(chk);
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back({op, addr, data});
    exp_frames++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = '0; rx_ready = 1'b0; cmd_ready = 1'b0;
    idle(2);
    n_cmp++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, chk_err, timeout_err, overrun_err, frame_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b op=%h cnt=%h required all zero", cmd_valid, cmd_op, frame_cnt);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    cmd_ready = 1'b1;
    expect_cmd(8'h01, 8'h10, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 1'b1);
    n_cmp++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, frame_cnt} !== {1'b1, 8'h01, 8'h10, 8'h3C, 16'd1}) begin
      n_err++;
      $display("FAIL basic_latency: valid=%b op=%h addr=%h wdata=%h cnt=%0d required 1 01 10 3c 1",
               cmd_valid, cmd_op, cmd_addr, cmd_wdata, frame_cnt);
    end
    idle(1);
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_drop: valid=%b required 0", cmd_valid);
    end
  endtask

  task automatic test_chk_err();
    int base;
    base = n_chk;
    send_frame(8'h01, 8'h10, 8'h3C, 1'b0);
    idle(2);
    n_cmp++;
    if (n_chk != base + 1 || cmd_valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL chk_err: pulses=%0d valid=%b cnt=%0d required %0d 0 %0d",
               n_chk - base, cmd_valid, frame_cnt, 1, exp_frames);
    end
    expect_cmd(8'h02, 8'h20, 8'h40);
    send_frame(8'h02, 8'h20, 8'h40, 1'b1);
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'h02 || frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL chk_recover: valid=%b op=%h cnt=%0d required 1 02 %0d", cmd_valid, cmd_op, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_garbage();
    int base;
    base = n_chk + n_tmo + n_ovr;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    expect_cmd(8'h01, 8'h10, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 1'b1);
    idle(2);
    n_cmp++;
    if (n_chk + n_tmo + n_ovr != base || frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL garbage: errors=%0d cnt=%0d required 0 %0d", n_chk + n_tmo + n_ovr - base, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_timeout();
    int base_t, base_c;
    base_t = n_tmo; base_c = n_chk;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(51);
    n_cmp++;
    if (n_tmo != base_t + 1) begin
      n_err++;
      $display("FAIL timeout_fire: pulses=%0d required 1", n_tmo - base_t);
    end
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h2D);
    idle(2);
    n_cmp++;
    if (cmd_valid !== 1'b0 || frame_cnt !== 16'(exp_frames) || n_chk != base_c) begin
      n_err++;
      $display("FAIL timeout_discard: valid=%b cnt=%0d chk=%0d required 0 %0d 0",
               cmd_valid, frame_cnt, n_chk - base_c, exp_frames);
    end
    // byte on the 49th idle clock keeps the frame alive
    base_t = n_tmo;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(47);
    send_byte(8'h10);
    expect_cmd(8'h01, 8'h10, 8'h3C);
    send_byte(8'h3C);
    send_byte(8'h2D);
    n_cmp++;
    if (n_tmo != base_t || cmd_valid !== 1'b1 || frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL timeout_edge: tmo=%0d valid=%b cnt=%0d required 0 1 %0d", n_tmo - base_t, cmd_valid, frame_cnt, exp_frames);
    end
    idle(2);
  endtask

  task automatic test_overrun();
    int base;
    base = n_ovr;
    cmd_ready = 1'b0;
    expect_cmd(8'h11, 8'h22, 8'h33);
    send_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_frame(8'h44, 8'h55, 8'h66, 1'b1);
    idle(2);
    n_cmp++;
    if (n_ovr != base + 1 || frame_cnt !== 16'(exp_frames) || cmd_valid !== 1'b1 ||
        {cmd_op, cmd_addr, cmd_wdata} !== 24'h112233) begin
      n_err++;
      $display("FAIL overrun: pulses=%0d cnt=%0d valid=%b cmd=%h required 1 %0d 1 112233",
               n_ovr - base, frame_cnt, cmd_valid, {cmd_op, cmd_addr, cmd_wdata}, exp_frames);
    end
    cmd_ready = 1'b1;
    idle(1);
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_release: valid=%b required 0", cmd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_ovr;
    cmd_ready = 1'b0;
    expect_cmd(8'hA5, 8'hA5, 8'h5A);
    send_frame(8'hA5, 8'hA5, 8'h5A, 1'b1);
    expect_cmd(8'h77, 8'h88, 8'h99);
    send_byte(8'hA5);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    // CHK byte and handshake land on the same edge
    @(posedge clk); #1;
    rx_data = 8'h77 ^ 8'h88 ^ 8'h99;
    rx_ready = 1'b1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    cmd_ready = 1'b0;
    n_cmp++;
    if (n_ovr != base || cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_wdata} !== 24'h778899 ||
        frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL b2b_load: ovr=%0d valid=%b cmd=%h cnt=%0d required 0 1 778899 %0d",
               n_ovr - base, cmd_valid, {cmd_op, cmd_addr, cmd_wdata}, frame_cnt, exp_frames);
    end
    idle(1);
    cmd_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_random();
    logic [7:0] op, addr, data;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 8'($urandom); addr = 8'($urandom); data = 8'($urandom);
      expect_cmd(op, addr, data);
      send_frame(op, addr, data, 1'b1);
    end
    idle(2);
    n_cmp++;
    if (frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL random_count: cnt=%0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_async_reset();
    cmd_ready = 1'b0;
    expect_cmd(8'h0F, 8'hF0, 8'h3C);
    send_frame(8'h0F, 8'hF0, 8'h3C, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_valid !== 1'b0 || frame_cnt !== 16'd0 || {cmd_op, cmd_addr, cmd_wdata} !== 24'h0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b cnt=%0d cmd=%h required 0 0 000000",
               cmd_valid, frame_cnt, {cmd_op, cmd_addr, cmd_wdata});
    end
    exp_q.delete();
    exp_frames = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_ready = 1'b1;
    send_byte(8'h3C);
    send_byte(8'h2D);
    idle(2);
    n_cmp++;
    if (cmd_valid !== 1'b0 || frame_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_tail: valid=%b cnt=%0d required 0 0", cmd_valid, frame_cnt);
    end
    expect_cmd(8'h01, 8'h10, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 1'b1);
    n_cmp++;
    if (cmd_valid !== 1'b1 || frame_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL reset_recover: valid=%b cnt=%0d required 1 1", cmd_valid, frame_cnt);
    end
    idle(2);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chk_err();
    test_garbage();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
